// File: rtl/bcd_serial_adder_7seg.sv
// Digit-serial packed-BCD adder with a free-running multiplexed 7-segment scanner.
// Optional feature: define LEAD_ZERO_BLANK_EN to blank leading zero digits on the display.
module bcd_serial_adder_7seg #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [W-1:0]     opa, opb, work;
    logic             carry, err_acc;
    logic [IDX_W-1:0] idx;
    logic [3:0]       a_d, b_d, dig;
    logic [4:0]       s;
    logic             c_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // One decimal digit per cycle; invalid digits still get the +6 correction.
    always_comb begin
        a_d   = opa[4*idx +: 4];
        b_d   = opb[4*idx +: 4];
        s     = {1'b0, a_d} + {1'b0, b_d} + {4'b0, carry};
        c_nxt = (s > 5'd9);
        dig   = c_nxt ? (s[3:0] + 4'd6) : s[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
            carry   <= 1'b0;
            err_acc <= 1'b0;
            idx     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        carry   <= 1'b0;
                        err_acc <= 1'b0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    carry   <= c_nxt;
                    err_acc <= err_acc | (a_d > 4'd9) | (b_d > 4'd9);
                    if (idx == IDX_W'(DIGITS - 1)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    sum   <= work;
                    cout  <= carry;
                    err   <= err_acc;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and working registers carry no reset; every digit is rewritten before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            opa <= a;
            opb <= b;
        end
        if (state == ADD)
            work[4*idx +: 4] <= dig;
    end

    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] sel;
    logic [W-1:0]     upper;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            sel   <= '0;
        end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
            presc <= '0;
            sel   <= (sel == IDX_W'(DIGITS - 1)) ? '0 : sel + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        upper = sum >> (4 * sel);
        seg   = seg7(sum[4*sel +: 4]);
        an    = DIGITS'(1) << sel;
`ifdef LEAD_ZERO_BLANK_EN
        // Digit 0 is never blanked so a zero sum still shows "0".
        if (sel != '0 && upper == '0) begin
            seg = 7'h00;
            an  = '0;
        end
`endif
    end

endmodule

// File: tb/tb_bcd_serial_adder_7seg.sv
// Randomized scoreboard bench for bcd_serial_adder_7seg (DIGITS=4, SCAN_DIV=4).
module tb_bcd_serial_adder_7seg;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [4*DIGITS-1:0] a_i = '0, b_i = '0;
    logic                busy, done, cout, err;
    logic [4*DIGITS-1:0] sum;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    bcd_serial_adder_7seg #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [17:0] expq[$];
    logic [15:0] disp_sum = '0;
    int scan_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: decimal integer addition when all digits are valid, else the digit rule.
    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        int xv = 0, yv = 0, sv, t;
        bit bad = 0;
        logic c = 1'b0;
        logic [15:0] r = '0;
        logic [3:0] xd, yd;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            xd = x[4*i +: 4];
            yd = y[4*i +: 4];
            if (xd > 9 || yd > 9) bad = 1;
            xv = xv * 10 + int'(xd);
            yv = yv * 10 + int'(yd);
        end
        if (!bad) begin
            sv = xv + yv;
            c  = (sv >= 10000);
            sv = sv % 10000;
            for (int i = 0; i < DIGITS; i++) begin
                r[4*i +: 4] = 4'(sv % 10);
                sv = sv / 10;
            end
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + int'(c);
                if (t > 9) begin
                    r[4*i +: 4] = 4'((t + 6) % 16);
                    c = 1'b1;
                end else begin
                    r[4*i +: 4] = 4'(t);
                    c = 1'b0;
                end
            end
        end
        return {bad, c, r};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d > 9) ? 7'h00 : tab[d];
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) scan_n <= 0;
        else     scan_n <= scan_n + 1;
    end

    // Monitor: pops expected results on done and checks the scanner every cycle.
    always @(negedge clk) begin
        logic [17:0] e;
        int sel_e;
        logic [DIGITS-1:0] an_e;
        logic [6:0] seg_e;
        if (rst) begin
            disp_sum = '0;
        end else begin
            if (done) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: got done=1 expected no pending add at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    chk("sum", 32'(sum), 32'(e[15:0]));
                    chk("cout", 32'(cout), 32'(e[16]));
                    chk("err", 32'(err), 32'(e[17]));
                    disp_sum = e[15:0];
                end
            end
            sel_e = (scan_n / SCAN_DIV) % DIGITS;
            an_e  = DIGITS'(1) << sel_e;
            seg_e = seg_of(disp_sum[4*sel_e +: 4]);
`ifdef LEAD_ZERO_BLANK_EN
            if (sel_e > 0 && (disp_sum >> (4 * sel_e)) == 16'h0) begin
                an_e  = '0;
                seg_e = 7'h00;
            end
`endif
            chk("an", 32'(an), 32'(an_e));
            chk("seg", 32'(seg), 32'(seg_e));
        end
    end

    task automatic do_add(input logic [15:0] x, input logic [15:0] y, input bit spur);
        @(negedge clk);
        a_i = x;
        b_i = y;
        start = 1'b1;
        @(posedge clk);
        expq.push_back(ref_add(x, y));
        for (int j = 0; j <= DIGITS + 2; j++) begin
            #1;
            chk("busy", 32'(busy), 32'(j < DIGITS));
            chk("done_timing", 32'(done), 32'(j == DIGITS + 1));
            a_i = 16'($urandom);
            b_i = 16'($urandom);
            start = (spur && j <= DIGITS) ? 1'b1 : 1'b0;
            if (j < DIGITS + 2) @(posedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_sum"},  32'(sum), 0);
        chk({tag, "_cout"}, 32'(cout), 0);
        chk({tag, "_err"},  32'(err), 0);
        chk({tag, "_an"},   32'(an), 1);
        chk({tag, "_seg"},  32'(seg), 32'h3F);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        do_add(16'h0019, 16'h0001, 1'b0);
        repeat (18) @(posedge clk);
        do_add(16'h9999, 16'h0001, 1'b0);
        repeat (18) @(posedge clk);
        do_add(16'h00A3, 16'h0001, 1'b0);
        repeat (18) @(posedge clk);
        do_add(16'h1234, 16'h0000, 1'b1);
        repeat (18) @(posedge clk);
        do_add(16'h0000, 16'h0007, 1'b0);
        repeat (18) @(posedge clk);
        do_add(16'h4567, 16'h5678, 1'b1);

        // Abort mid-add: no done, outputs return to reset values.
        @(negedge clk);
        a_i = 16'h1111;
        b_i = 16'h2222;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("abort");
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (DIGITS + 4) @(posedge clk);
        #1 chk("abort_sum_held", 32'(sum), 0);

        for (int n = 0; n < 30; n++) begin
            do_add(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        #1 chk("queue_drained", 32'(expq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
